alu_seq: RTL and testbench

- Parametrised, handshaked successor to the datapath ALU.
- Keeps the existing aluCtr encoding and aluSrc operand mux.
- Registers every result and adds iterative multi-cycle unsigned multiply and divide.
- Sits between the register-file/immediate stage and writeback; the pipeline controller stalls on in_ready/out_valid.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with iterative unsigned multiply
// and optional restoring divide (build with ALU_SEQ_DIV_EN for divu).
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready   request handshake, accepted only when idle
//   input1, input2        operand A, register operand B
//   aluSrc, data          B select (1: data) and immediate operand B
//   aluCtr                operation select
//   out_valid / out_ready result handshake, result held until taken
//   aluRes, aluResHi      low word / quotient, high word / remainder
//   zero                  aluRes == 0, registered with the result
//   busy                  multi-cycle op in progress
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             aluSrc,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       aluCtr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluRes,
    output logic [WIDTH-1:0] aluResHi,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
`endif

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_w;
    logic [WIDTH-1:0] lo_w;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] alu_hi;
    logic             go_mul;
    logic             accept;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo;

    assign op_b   = aluSrc ? data : input2;
    assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_DIV_EN
    logic             go_div;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
`endif

    // Single-cycle results are formed straight from the live inputs so
    // they can be registered on the accepting edge.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        go_mul = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        go_div = 1'b0;
`endif
        case (aluCtr)
            OP_ADD: alu_lo = input1 + op_b;
            OP_SUB: alu_lo = input1 - op_b;
            OP_AND: alu_lo = input1 & op_b;
            OP_OR:  alu_lo = input1 | op_b;
            OP_SLT: alu_lo = {{(WIDTH-1){1'b0}}, input1 < op_b};
            OP_NOR: alu_lo = ~(input1 | op_b);
            OP_MUL: go_mul = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                // Divide by zero never enters the iterative loop.
                if (op_b == '0) begin
                    alu_lo = '1;
                    alu_hi = input1;
                end else begin
                    go_div = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Shift-add step: {hi_w, lo_w} shifts right as multiplier bits retire.
    assign mul_sum = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opnd} : '0);
    assign mul_lo  = {mul_sum[0], lo_w[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // Restoring step: partial remainder in hi_w, dividend/quotient in lo_w.
    // The top bit of the difference is the borrow, since the shifted
    // remainder is always below twice the divisor.
    assign div_shift = {hi_w, lo_w[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {lo_w[WIDTH-2:0], div_ge};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            aluRes    <= '0;
            aluResHi  <= '0;
            zero      <= 1'b0;
            cnt       <= '0;
            opnd      <= '0;
            hi_w      <= '0;
            lo_w      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (go_mul) begin
                            state <= MUL;
                            busy  <= 1'b1;
                            opnd  <= input1;
                            hi_w  <= '0;
                            lo_w  <= op_b;
                            cnt   <= CNT_W'(WIDTH - 1);
`ifdef ALU_SEQ_DIV_EN
                        end else if (go_div) begin
                            state <= DIV;
                            busy  <= 1'b1;
                            opnd  <= op_b;
                            hi_w  <= '0;
                            lo_w  <= input1;
                            cnt   <= CNT_W'(WIDTH - 1);
`endif
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            aluRes    <= alu_lo;
                            aluResHi  <= alu_hi;
                            zero      <= (alu_lo == '0);
                        end
                    end
                end
                MUL: begin
                    hi_w <= mul_sum[WIDTH:1];
                    lo_w <= mul_lo;
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        aluRes    <= mul_lo;
                        aluResHi  <= mul_sum[WIDTH:1];
                        zero      <= (mul_lo == '0);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                DIV: begin
                    hi_w <= div_rem;
                    lo_w <= div_quo;
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        aluRes    <= div_quo;
                        aluResHi  <= div_rem;
                        zero      <= (div_quo == '0);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH = 32).
// Expected results are queued at issue and compared on retirement.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        aluSrc;
    logic [31:0] data;
    logic [3:0]  aluCtr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluRes;
    logic [31:0] aluResHi;
    logic        zero;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];
    logic [63:0] sb_e;

    localparam logic [3:0] OPS [10] = '{
        4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9, 4'h3, 4'hF
    };

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .aluSrc    (aluSrc),
        .data      (data),
        .aluCtr    (aluCtr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluRes    (aluRes),
        .aluResHi  (aluResHi),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result as {hi, lo}.
    function automatic logic [63:0] model(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            4'b0010: return {32'd0, a + b};
            4'b0110: return {32'd0, a - b};
            4'b0000: return {32'd0, a & b};
            4'b0001: return {32'd0, a | b};
            4'b0111: return {32'd0, 31'd0, a < b};
            4'b1100: return {32'd0, ~(a | b)};
            4'b1000: return {32'd0, a} * {32'd0, b};
`ifdef ALU_SEQ_DIV_EN
            4'b1001: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
`endif
            default: return 64'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("aluRes", {32'd0, aluRes}, {32'd0, sb_e[31:0]});
                check("aluResHi", {32'd0, aluResHi}, {32'd0, sb_e[63:32]});
                check("zero", zero, sb_e[31:0] == 32'd0);
            end
        end
    end

    // Drive one op for a single accept cycle, scramble inputs while it
    // runs, and check latency, busy duration and in_ready. Retires it
    // when out_ready is high.
    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b_reg, input logic src,
                         input logic [31:0] imm);
        logic [31:0] b;
        int lat;
        int edges;
        int busy_n;
        int rdy_n;
        b   = src ? imm : b_reg;
        lat = 1;
        if (c == 4'b1000) lat = 33;
`ifdef ALU_SEQ_DIV_EN
        if (c == 4'b1001 && b != 0) lat = 33;
`endif
        check("in_ready_idle", in_ready, 1);
        aluCtr   = c;
        input1   = a;
        input2   = b_reg;
        aluSrc   = src;
        data     = imm;
        in_valid = 1'b1;
        sb_q.push_back(model(c, a, b));
        edges  = 0;
        busy_n = 0;
        rdy_n  = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_n++;
            if (in_ready) rdy_n++;
            in_valid = 1'($urandom_range(0, 1));
            input1   = $urandom;
            input2   = $urandom;
            data     = $urandom;
            aluSrc   = 1'($urandom_range(0, 1));
            aluCtr   = 4'($urandom_range(0, 15));
        end while (!out_valid && edges < 100);
        in_valid = 1'b0;
        check("latency", edges, lat);
        check("busy_cycles", busy_n, lat - 1);
        check("in_ready_busy", rdy_n, 0);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("retire_valid", out_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running, required finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        input1    = '0;
        input2    = '0;
        aluSrc    = 1'b0;
        data      = '0;
        aluCtr    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res", {32'd0, aluRes}, 0);
        check("rst_hi", {32'd0, aluResHi}, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);

        issue(4'b0010, 32'd5, 32'd7, 1'b0, 32'd99);
        issue(4'b0110, 32'd9, 32'd3, 1'b1, 32'd9);
        issue(4'b0111, 32'd3, 32'hFFFF_FFFF, 1'b0, 32'd0);
        issue(4'b1100, 32'd0, 32'd0, 1'b0, 32'd0);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0);
        issue(4'b1001, 32'd100, 32'd7, 1'b0, 32'd0);
        issue(4'b1001, 32'd100, 32'd0, 1'b0, 32'd0);
        issue(4'b1001, 32'd6, 32'd99, 1'b1, 32'd0);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd5, 1'b1, 32'hFFFF_FFFF);
        issue(4'b0101, 32'd12, 32'd34, 1'b0, 32'd0);

        for (int i = 0; i < 12; i++) begin
            issue(OPS[$urandom_range(0, 9)], $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom);
        end

        out_ready = 1'b0;
        issue(4'b0010, 32'h1234, 32'h10, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            input1   = $urandom;
            input2   = $urandom;
            aluCtr   = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_res", {32'd0, aluRes}, 64'h1244);
            check("bp_hi", {32'd0, aluResHi}, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_retire_valid", out_valid, 0);
        check("bp_retire_ready", in_ready, 1);

        aluCtr   = 4'b1000;
        input1   = 32'hFFFF_FFFF;
        input2   = 32'd3;
        aluSrc   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_mul_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_res", {32'd0, aluRes}, 0);
        check("arst_hi", {32'd0, aluResHi}, 0);
        check("arst_zero", zero, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_ready", in_ready, 1);
        issue(4'b0010, 32'd1, 32'd1, 1'b0, 32'd0);

        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
